// File: rtl/idct_transpose8x8.sv
// rtl/idct_transpose8x8.sv - ping-pong 8x8 transpose buffer between IDCT row and column passes
// Rows are written into one bank while the other bank is read out column by column.
module idct_transpose8x8 #(
    parameter int DataWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [8*DataWidth-1:0] s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [8*DataWidth-1:0] m_data_o,
    output logic [2:0]             m_col_o,
    output logic                   m_last_o
);

    logic [DataWidth-1:0] bank_q [2][8][8];

    logic [1:0] full_q,    full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] rd_col_q,  rd_col_d;

    logic s_fire;
    logic m_fire;

    // Full flags alone gate both sides, so no bank is ever written and read at once.
    assign s_ready_o = !full_q[wr_bank_q];
    assign m_valid_o = full_q[rd_bank_q];
    assign s_fire    = s_valid_i && s_ready_o;
    assign m_fire    = m_valid_o && m_ready_i;
    assign m_col_o   = rd_col_q;
    assign m_last_o  = m_valid_o && (rd_col_q == 3'd7);

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        if (s_fire) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (m_fire) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Element 0 sits in the most significant slice of the packed row vector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        bank_q[b][r][c] <= '0;
                    end
                end
            end
        end else if (s_fire) begin
            for (int c = 0; c < 8; c++) begin
                bank_q[wr_bank_q][wr_row_q][c] <= s_data_i[(7-c)*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        m_data_o = '0;
        for (int r = 0; r < 8; r++) begin
            m_data_o[(7-r)*DataWidth +: DataWidth] = bank_q[rd_bank_q][r][rd_col_q];
        end
    end

endmodule
